branch_step_ctrl: RTL and testbench

//  Control-step sequencer for conditional branch instructions (brzr/brnz/brpl/brmi).
//  It drives the strobes that feed the CON FF (Gra, Rout, CONin) and later consumes the CON FF result.

---
 rtl/branch_step_ctrl_if.sv | 33 +++
 rtl/branch_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_branch_step_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/branch_step_ctrl_if.sv
// Bus/strobe bundle between the branch step sequencer and the datapath.
// The control unit side is the master; the sequencer is the slave.
interface branch_step_ctrl_if;
    logic        start;
    logic [31:0] ir;
    logic        con_ff;
    logic        gra;
    logic        r_out;
    logic        con_in;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        zlow_out;
    logic        pc_in;
    logic        busy;
    logic        done;
    logic        taken;
    logic        illegal;

    modport master (
        output start, ir, con_ff,
        input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               zlow_out, pc_in, busy, done, taken, illegal
    );

    modport slave (
        input  start, ir, con_ff,
        output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               zlow_out, pc_in, busy, done, taken, illegal
    );
endinterface

// File: rtl/branch_step_ctrl.sv
// Execute-step sequencer (T3..T6) for brzr/brnz/brpl/brmi.
// Optional taken/not-taken saturating counters are enabled with BRANCH_STATS_EN.
module branch_step_ctrl #(
    parameter logic [4:0] BR_OPCODE = 5'b10011,
    parameter int         STAT_W    = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    branch_step_ctrl_if.slave     bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]     taken_cnt,
    output logic [STAT_W-1:0]     not_taken_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cond_q, cond_d;
    logic       taken_q, taken_d;
    logic       illegal_q, illegal_d;
    logic       is_branch;

    assign is_branch = (bus.ir[31:27] == BR_OPCODE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cond_q    <= 2'b00;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        taken_d   = taken_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_branch) begin
                        state_d = S_T3;
                        cond_d  = bus.ir[20:19];
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_T3: state_d = S_T4;
            S_T4: begin
                taken_d = bus.con_ff;
                state_d = S_T5;
            end
            S_T5: state_d = S_T6;
            S_T6: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The PC load is gated by clear so a reset landing in T6 never commits a branch.
    always_comb begin
        bus.gra      = 1'b0;
        bus.r_out    = 1'b0;
        bus.con_in   = 1'b0;
        bus.pc_out   = 1'b0;
        bus.y_in     = 1'b0;
        bus.c_out    = 1'b0;
        bus.alu_add  = 1'b0;
        bus.z_in     = 1'b0;
        bus.zlow_out = 1'b0;
        bus.pc_in    = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            S_T3: begin
                bus.gra    = 1'b1;
                bus.r_out  = 1'b1;
                bus.con_in = 1'b1;
            end
            S_T4: begin
                bus.pc_out = 1'b1;
                bus.y_in   = 1'b1;
            end
            S_T5: begin
                bus.c_out   = 1'b1;
                bus.alu_add = 1'b1;
                bus.z_in    = 1'b1;
            end
            S_T6: begin
                bus.done     = 1'b1;
                bus.zlow_out = taken_q & ~clear;
                bus.pc_in    = taken_q & ~clear;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.taken   = taken_q;
    assign bus.illegal = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [STAT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    // Counters saturate rather than wrap.
    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (state_q == S_T6) begin
            if (taken_q) begin
                if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + STAT_W'(1);
            end else begin
                if (not_taken_cnt_q != '1) not_taken_cnt_d = not_taken_cnt_q + STAT_W'(1);
            end
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

    // cond_q is kept for datapath debug visibility; the CON FF evaluates it externally.
    logic unused_ok;
    assign unused_ok = ^{bus.ir[26:21], bus.ir[18:0], cond_q};

endmodule

// File: tb/tb_branch_step_ctrl.sv
// Randomized self-checking bench for branch_step_ctrl with a step-table reference model.
module tb_branch_step_ctrl;
    localparam logic [4:0] BR = 5'b10011;
`ifdef BRANCH_STATS_EN
    localparam int STAT_W = 3;
`else
    localparam int STAT_W = 16;
`endif

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    branch_step_ctrl_if bi ();
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt, not_taken_cnt;
    branch_step_ctrl #(.BR_OPCODE(BR), .STAT_W(STAT_W)) dut (
        .clock(clock), .clear(clear), .bus(bi),
        .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt));
`else
    branch_step_ctrl #(.BR_OPCODE(BR), .STAT_W(STAT_W)) dut (
        .clock(clock), .clear(clear), .bus(bi));
`endif

    int n_chk = 0;
    int n_err = 0;
    bit m_taken = 1'b0;
    int m_tcnt = 0;
    int m_ncnt = 0;
    int sat_max = (1 << STAT_W) - 1;

    logic [13:0] obs;
    assign obs = {bi.gra, bi.r_out, bi.con_in, bi.pc_out, bi.y_in, bi.c_out, bi.alu_add,
                  bi.z_in, bi.zlow_out, bi.pc_in, bi.busy, bi.done, bi.taken, bi.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected output vector for a given execute step (0 = idle, 1..4 = T3..T6).
    function automatic logic [13:0] expv(input int step, input bit tk, input bit ill);
        logic [13:0] v;
        v = '0;
        case (step)
            1: v[13:11] = 3'b111;
            2: v[10:9]  = 2'b11;
            3: v[8:6]   = 3'b111;
            4: begin v[2] = 1'b1; v[5] = tk; v[4] = tk; end
            default: ;
        endcase
        v[3] = (step != 0);
        v[1] = tk;
        v[0] = ill;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BRANCH_STATS_EN
        chk({tag, "_tcnt"}, 32'(taken_cnt), 32'(m_tcnt));
        chk({tag, "_ncnt"}, 32'(not_taken_cnt), 32'(m_ncnt));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        m_taken = 1'b0; m_tcnt = 0; m_ncnt = 0;
        #1;
        chk("clear_idle", 32'(obs), 32'(expv(0, 1'b0, 1'b0)));
        chk_stats("clear");
    endtask

    // One start pulse; clr_step (1..4) asserts clear during that execute step.
    task automatic run_op(input logic [4:0] op, input logic [1:0] cond, input bit cf,
                          input bit noise, input int clr_step);
        logic [31:0] instr;
        logic [13:0] e;
        instr = $urandom;
        instr[31:27] = op;
        instr[20:19] = cond;
        bi.start = 1'b1; bi.ir = instr; bi.con_ff = 1'($urandom_range(0, 1));
        cyc();
        bi.start = 1'b0;
        if (op != BR) begin
            #1;
            chk("illegal_pulse", 32'(obs), 32'(expv(0, m_taken, 1'b1)));
            cyc();
            chk("illegal_end", 32'(obs), 32'(expv(0, m_taken, 1'b0)));
            return;
        end
        for (int step = 1; step <= 4; step++) begin
            bi.start = 1'b0;
            if (noise) begin
                bi.ir = $urandom;
                bi.start = 1'($urandom_range(0, 1));
            end
            bi.con_ff = (step == 2) ? cf : 1'($urandom_range(0, 1));
            if (step == clr_step) clear = 1'b1;
            #1;
            e = expv(step, m_taken, 1'b0);
            if (step == clr_step && step == 4) e[5:4] = 2'b00;
            chk($sformatf("step%0d", step), 32'(obs), 32'(e));
            chk("bus_drivers", 32'($countones({bi.r_out, bi.pc_out, bi.c_out, bi.zlow_out}) <= 1), 32'd1);
            cyc();
            if (clear) begin
                clear = 1'b0;
                bi.start = 1'b0;
                m_taken = 1'b0; m_tcnt = 0; m_ncnt = 0;
                #1;
                chk("after_clear", 32'(obs), 32'(expv(0, 1'b0, 1'b0)));
                chk_stats("after_clear");
                return;
            end
            if (step == 2) m_taken = cf;
            if (step == 4) begin
                if (m_taken) m_tcnt = (m_tcnt < sat_max) ? m_tcnt + 1 : m_tcnt;
                else         m_ncnt = (m_ncnt < sat_max) ? m_ncnt + 1 : m_ncnt;
            end
        end
        bi.start = 1'b0;
        #1;
        chk("idle_after", 32'(obs), 32'(expv(0, m_taken, 1'b0)));
        chk_stats("idle_after");
    endtask

    function automatic logic [4:0] bad_op();
        logic [4:0] o;
        o = 5'($urandom_range(0, 31));
        if (o == BR) o = 5'b00011;
        return o;
    endfunction

    initial begin
        clear = 1'b1; bi.start = 1'b0; bi.ir = '0; bi.con_ff = 1'b0;
        cyc(); cyc();
        chk("reset", 32'(obs), 32'(expv(0, 1'b0, 1'b0)));
        chk_stats("reset");
        clear = 1'b0;
        cyc();

        run_op(BR, 2'b00, 1'b1, 1'b0, 0);          // brzr taken
        do_clear();                                 // clear in IDLE drops taken
        run_op(BR, 2'b01, 1'b0, 1'b0, 0);          // brnz not taken
        run_op(5'b00011, 2'b00, 1'b0, 1'b0, 0);    // illegal opcode
        run_op(BR, 2'b10, 1'b1, 1'b0, 3);          // clear during T5
        run_op(BR, 2'b11, 1'b1, 1'b0, 0);          // normal after clear
        run_op(BR, 2'b00, 1'b1, 1'b0, 4);          // clear during T6: no PC load
        run_op(BR, 2'b01, 1'b1, 1'b1, 0);          // restart/ir noise mid-op
        run_op(BR, 2'b10, 1'b0, 1'b1, 0);

`ifdef BRANCH_STATS_EN
        do_clear();
        run_op(BR, 2'b00, 1'b1, 1'b0, 0);
        run_op(BR, 2'b00, 1'b0, 1'b0, 0);
        run_op(BR, 2'b00, 1'b1, 1'b0, 0);
        run_op(BR, 2'b00, 1'b0, 1'b0, 0);
        run_op(BR, 2'b00, 1'b1, 1'b0, 0);
        chk("stats_3t", 32'(taken_cnt), 32'd3);
        chk("stats_2n", 32'(not_taken_cnt), 32'd2);
        for (int i = 0; i < 6; i++) run_op(BR, 2'b00, 1'b1, 1'b0, 0);
        chk("stats_sat", 32'(taken_cnt), 32'(sat_max));
`endif

        for (int i = 0; i < 60; i++) begin
            bit legal;
            int cs;
            legal = ($urandom_range(0, 3) != 0);
            cs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(legal ? BR : bad_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), cs);
            if ($urandom_range(0, 3) == 0) cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
